mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit MIPS-style processor. Sits directly upstream of the register file.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Generates every datapath strobe, including the single-cycle RegWrite pulse into the register file.
- Waits on a memory ready handshake for instruction and data accesses.

Parameters:
- OP_W, 3, opcode width (instr[7:5]).
- ALUOP_W, 2, width of alu_op output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  opcode field from instruction register (valid from DECODE onward).
- zero  in  1  ALU zero flag (valid in EXEC).
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  unconditional PC load strobe.
- pc_src  out  2  00=PC+1, 01=branch target, 10=jump target.
- ir_write  out  1  instruction register load.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  0=instruction address, 1=data address.
- alu_op  out  ALUOP_W  00=add, 01=sub, 10=pass B.
- alu_src_b  out  1  0=register B, 1=sign-extended immediate.
- reg_dst  out  1  0=rt field, 1=rd field as write address.
- mem_to_reg  out  1  0=ALU result, 1=memory data register.
- reg_write  out  1  register-file write enable (RegWrite).
- halted  out  1  FSM in HALT.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset: rst_n low sets state=FETCH(000) asynchronously and forces all outputs to 0 regardless of state.
- After rst_n deasserts, FETCH outputs appear combinationally.
- State encodings: FETCH=000, DECODE=001, EXEC=010, MEM_RD=011, MEM_WR=100, WB=101, HALT=110. Encoding 111 is illegal and goes to FETCH on the next edge.
- Opcodes: 000 ADD, 001 SUB, 010 LW, 011 SW, 100 BEQ, 101 ADDI, 110 J, 111 HALT.
- FETCH:
  - mem_read=1, i_or_d=0.
  - ir_write, pc_write and pc_src=00 are asserted only in the cycle mem_ready=1 (Mealy).
  - Then → DECODE. Stays in FETCH while mem_ready=0.
- DECODE (1 cycle, no strobes):
  - HALT → HALT.
  - J → EXEC.
  - All other opcodes → EXEC.
- EXEC:
  - ADD: alu_op=00, alu_src_b=0 → WB.
  - SUB: alu_op=01, alu_src_b=0 → WB.
  - ADDI: alu_op=00, alu_src_b=1 → WB.
  - LW: alu_op=00, alu_src_b=1 → MEM_RD.
  - SW: alu_op=00, alu_src_b=1 → MEM_WR.
  - BEQ: alu_op=01, alu_src_b=0. pc_write=zero, pc_src=01 → FETCH.
  - J: pc_write=1, pc_src=10 → FETCH.
- MEM_RD: mem_read=1, i_or_d=1. Advances to WB when mem_ready=1, otherwise holds.
- MEM_WR:
  - mem_write=1, i_or_d=1 while waiting.
  - → FETCH when mem_ready=1.
  - mem_write stays high every wait cycle.
- WB:
  - reg_write=1 for exactly one cycle.
  - reg_dst=1 for ADD/SUB; reg_dst=0 for ADDI/LW.
  - mem_to_reg=1 only for LW.
  - → FETCH.
- HALT: halted=1, all strobes 0. Remains in HALT until reset.
- Latency with zero wait states:
  - ADD/SUB/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/J: 3 cycles.
  - Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds 1.
- Opcode is sampled combinationally in DECODE, EXEC and WB; the datapath holds the IR stable from DECODE to the next FETCH.
- mem_ready is ignored in all states except FETCH, MEM_RD and MEM_WR.
- Invariants: reg_write and mem_write never high together; mem_read and mem_write never high together.
- Reset mid-instruction (e.g. during WB): reg_write drops immediately. No partial write is carried over.

Optional Feature:
- Macro: MIPS_CTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output retired_cnt (16 bits), reset to 0.
  - Increments by 1 on the final cycle of each instruction: the WB cycle, the MEM_WR cycle with mem_ready=1, the EXEC cycle of BEQ/J, or the DECODE cycle of HALT (counted once).
  - Wraps 0xFFFF→0x0000.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 → all outputs 0, state=000. Release → mem_read=1, i_or_d=0 in the same cycle.
- ADD, zero wait: opcode=000, mem_ready=1 → states 000,001,010,101,000. reg_write=1 only in cycle 4 with reg_dst=1, mem_to_reg=0.
- LW with 2 wait cycles in MEM_RD: opcode=010, mem_ready low 2 cycles then high → MEM_RD held 3 cycles. Then WB with reg_write=1, mem_to_reg=1, reg_dst=0. Total 7 cycles.
- BEQ: zero=1 → pc_write=1, pc_src=01 in EXEC. zero=0 → pc_write=0 in EXEC. reg_write never asserted in either case.
- HALT: opcode=111 → halted=1 from cycle 3 and stays for 20 cycles with no strobes. Pulsing rst_n low → state=000.
- Reset during WB: assert rst_n=0 mid-cycle in WB → reg_write falls without waiting for a clock edge. With MIPS_CTRL_RETIRE_CNT_EN: 5 ADDs → retired_cnt=5; a preload-style run past 65535 retires → wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS-style core: fetch/decode/exec/mem/writeback sequencing.
// Optional retired-instruction counter enabled by defining MIPS_CTRL_RETIRE_CNT_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_b,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               halted,
`ifdef MIPS_CTRL_RETIRE_CNT_EN
  output logic [15:0]        retired_cnt,
`endif
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMemRd  = 3'b011,
    StMemWr  = 3'b100,
    StWb     = 3'b101,
    StHalt   = 3'b110
  } state_e;

  localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
  localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
  localparam logic [OP_W-1:0] OpLw   = OP_W'(2);
  localparam logic [OP_W-1:0] OpSw   = OP_W'(3);
  localparam logic [OP_W-1:0] OpBeq  = OP_W'(4);
  localparam logic [OP_W-1:0] OpAddi = OP_W'(5);
  localparam logic [OP_W-1:0] OpJ    = OP_W'(6);
  localparam logic [OP_W-1:0] OpHalt = OP_W'(7);

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);

  localparam logic [1:0] PcSrcSeq    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: state_d = (opcode == OpHalt) ? StHalt : StExec;
      StExec: begin
        case (opcode)
          OpAdd, OpSub, OpAddi: state_d = StWb;
          OpLw:                 state_d = StMemRd;
          OpSw:                 state_d = StMemWr;
          default:              state_d = StFetch;
        endcase
      end
      StMemRd:  if (mem_ready) state_d = StWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      // Covers the unused 3'b111 encoding.
      default:  state_d = StFetch;
    endcase
  end

  // Outputs are gated by rst_n so an asserted reset kills every strobe before the next edge.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PcSrcSeq;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_op     = AluAdd;
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        StExec: begin
          case (opcode)
            OpSub: alu_op = AluSub;
            OpLw, OpSw, OpAddi: alu_src_b = 1'b1;
            OpBeq: begin
              alu_op   = AluSub;
              pc_write = zero;
              pc_src   = PcSrcBranch;
            end
            OpJ: begin
              pc_write = 1'b1;
              pc_src   = PcSrcJump;
            end
            default: ;
          endcase
        end
        StMemRd: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        StWb: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OpAdd) || (opcode == OpSub);
          mem_to_reg = (opcode == OpLw);
        end
        StHalt: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

`ifdef MIPS_CTRL_RETIRE_CNT_EN
  logic        retire;
  logic [15:0] retired_cnt_q;

  // Final cycle of each instruction; HALT retires once, on its DECODE cycle.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StDecode: retire = (opcode == OpHalt);
      StExec:   retire = (opcode == OpBeq) || (opcode == OpJ);
      StMemWr:  retire = mem_ready;
      StWb:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= 16'd0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_q + 16'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
